ladner_fischer_approx_pipe: RTL and testbench

Parametrised, pipelined successor to the fixed 16-bit K=6 approximate Ladner-Fischer adder. Operand width and approximation depth are parameters. Exact/approximate mode is selectable per transaction. The result flows through a valid/ready pipeline with configurable depth. An on-line error monitor compares the approximate result against the exact sum and keeps a saturating mismatch counter. It sits between operand producers and accumulate/MAC datapaths in the approximate-arithmetic evaluation fabric.

---
 rtl/ladner_fischer_approx_pipe_if.sv | 27 ++
 rtl/ladner_fischer_approx_pipe.sv | 148 ++++++++++++++
 tb/tb_ladner_fischer_approx_pipe.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ladner_fischer_approx_pipe_if.sv
// Operand/result stream bundle for the approximate Ladner-Fischer adder pipeline.
interface ladner_fischer_approx_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             approx_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   sum;
   logic             mismatch;

   // Producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid, a, b, carry_in, approx_en, out_ready,
      input  in_ready, out_valid, sum, mismatch
   );

   // Adder side
   modport slave (
      input  in_valid, a, b, carry_in, approx_en, out_ready,
      output in_ready, out_valid, sum, mismatch
   );
endinterface

// File: rtl/ladner_fischer_approx_pipe.sv
// Parametrised approximate/exact Ladner-Fischer adder with a valid/ready
// pipeline and an on-line saturating mismatch counter.
module ladner_fischer_approx_pipe #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned K      = 6,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   ladner_fischer_approx_pipe_if.slave  bus,
   input  logic                         err_clr,
   output logic [CNT_W-1:0]             err_cnt
);

   localparam int unsigned LVL     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int          KI      = int'(K);
   localparam int unsigned LAST    = STAGES - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Sparse minimum-depth prefix tree: returns group generate G[0..i] per bit.
   function automatic logic [WIDTH-1:0] lf_prefix(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] gn;
      logic [WIDTH-1:0] pn;
      int               j;
      g = g_in;
      p = p_in;
      for (int l = 0; l < int'(LVL); l++) begin
         gn = g;
         pn = p;
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (((i >> l) & 1) == 1) begin
               // last node of the preceding aligned block of size 2^l
               j     = ((i >> l) << l) - 1;
               gn[i] = g[i] | (p[i] & g[j]);
               pn[i] = p[i] & p[j];
            end
         end
         g = gn;
         p = pn;
      end
      return g;
   endfunction

   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_gx;
   logic [WIDTH-1:0] w_c_exa;
   logic [WIDTH-1:0] w_c_apx;
   logic [WIDTH-1:0] w_ga;
   logic [WIDTH-1:0] w_pa;
   logic [WIDTH:0]   w_sum_exa;
   logic [WIDTH:0]   w_sum_apx;
   logic [WIDTH:0]   w_sum_sel;
   logic             w_mismatch;
   logic             w_adv;
   logic             w_count;

   logic [STAGES-1:0]            r_vld;
   logic [STAGES-1:0]            r_apx;
   logic [STAGES-1:0]            r_mis;
   logic [STAGES-1:0][WIDTH:0]   r_sum;
   logic [CNT_W-1:0]             r_err_cnt;

   assign w_p = bus.a ^ bus.b;
   assign w_g = bus.a & bus.b;

   // Fold carry_in into bit 0 generate so the prefix tree yields true carries
   always_comb begin
      w_gx    = w_g;
      w_gx[0] = w_g[0] | (w_p[0] & bus.carry_in);
   end

   assign w_c_exa   = lf_prefix(w_gx, w_p);
   assign w_sum_exa = {w_c_exa[WIDTH-1], w_p ^ {w_c_exa[WIDTH-2:0], bus.carry_in}};

   // Approximate carries: low K bits keep only local generate; the upper region
   // is a prefix over bits K.. seeded with c_{K-1} = g_{K-1}
   always_comb begin
      w_ga = '0;
      w_pa = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i == KI - 1) begin
            w_ga[i] = w_g[i];
         end else if (i >= KI) begin
            w_ga[i] = w_gx[i];
            w_pa[i] = w_p[i];
         end
      end
      w_c_apx = lf_prefix(w_ga, w_pa);
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i < KI) begin
            w_c_apx[i] = w_g[i];
         end
      end
   end

   assign w_sum_apx  = {w_c_apx[WIDTH-1], w_p ^ {w_c_apx[WIDTH-2:0], bus.carry_in}};
   assign w_mismatch = (w_sum_apx != w_sum_exa);
   assign w_sum_sel  = bus.approx_en ? w_sum_apx : w_sum_exa;

   // Single global advance: everything moves unless a result is stuck at the output
   assign w_adv        = !r_vld[LAST] | bus.out_ready;
   assign bus.in_ready = w_adv;

   // Result pipeline; bubbles shift along with valid beats
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_apx <= '0;
         r_mis <= '0;
         r_sum <= '0;
      end else if (w_adv) begin
         r_vld[0] <= bus.in_valid;
         r_apx[0] <= bus.approx_en;
         r_mis[0] <= w_mismatch;
         r_sum[0] <= w_sum_sel;
         for (int s = 1; s < int'(STAGES); s++) begin
            r_vld[s] <= r_vld[s-1];
            r_apx[s] <= r_apx[s-1];
            r_mis[s] <= r_mis[s-1];
            r_sum[s] <= r_sum[s-1];
         end
      end
   end

   assign w_count = r_vld[LAST] & bus.out_ready & r_apx[LAST] & r_mis[LAST];

   // Saturating count of delivered approximate beats that differ from exact; clear wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (err_clr) begin
         r_err_cnt <= '0;
      end else if (w_count && (r_err_cnt != CNT_MAX)) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign bus.out_valid = r_vld[LAST];
   assign bus.sum       = r_sum[LAST];
   assign bus.mismatch  = r_mis[LAST];
   assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_ladner_fischer_approx_pipe.sv
// Scoreboard bench: DUT0 is K=6/CNT_W=4, DUT1 is K=0 (exact) on the same stream.
module tb_ladner_fischer_approx_pipe;

   typedef struct packed {
      logic [16:0] sum;
      logic        mis;
      logic        apx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        apx = 1'b0;
   logic        out_ready = 1'b1;
   logic        err_clr = 1'b0;
   logic [3:0]  err_cnt0;
   logic [15:0] err_cnt1;

   int checks = 0;
   int errors = 0;

   exp_t        q [2][$];
   int          m_cnt [2];
   int          pop_cnt [2];
   logic        hold_v [2];
   logic [16:0] hold_sum [2];
   logic        hold_mis [2];
   logic        prev_rst [2];
   logic        started = 1'b0;
   logic        done = 1'b0;

   ladner_fischer_approx_pipe_if #(.WIDTH(16)) if0 ();
   ladner_fischer_approx_pipe_if #(.WIDTH(16)) if1 ();

   assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
   assign if0.a = a;                assign if1.a = a;
   assign if0.b = b;                assign if1.b = b;
   assign if0.carry_in = cin;       assign if1.carry_in = cin;
   assign if0.approx_en = apx;      assign if1.approx_en = apx;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

   ladner_fischer_approx_pipe #(.WIDTH(16), .K(6), .STAGES(2), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .bus(if0), .err_clr(err_clr), .err_cnt(err_cnt0));
   ladner_fischer_approx_pipe #(.WIDTH(16), .K(0), .STAGES(2), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .bus(if1), .err_clr(err_clr), .err_cnt(err_cnt1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Bit-level reference: ripple form of the approximate carry rule plus a+b+cin
   function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb,
                                  input logic xc, input logic xx, input int k);
      exp_t        e;
      logic [16:0] ap;
      logic [16:0] ex;
      logic        c;
      logic        p;
      logic        g;
      c = xc;
      for (int i = 0; i < 16; i++) begin
         p     = xa[i] ^ xb[i];
         g     = xa[i] & xb[i];
         ap[i] = p ^ c;
         c     = (i < k) ? g : (g | (p & c));
      end
      ap[16] = c;
      ex     = 17'(xa) + 17'(xb) + 17'(xc);
      e.mis  = (ap != ex);
      e.sum  = xx ? ap : ex;
      e.apx  = xx;
      return e;
   endfunction

   task automatic mon(input int d, input logic irdy, input logic ovld, input logic [16:0] osum,
                      input logic omis, input logic [15:0] ecnt, input int emax);
      exp_t e;
      logic xfer;
      if (rst) begin
         q[d].delete();
         m_cnt[d]    = 0;
         hold_v[d]   = 1'b0;
         prev_rst[d] = 1'b1;
         started     = 1'b1;
         return;
      end
      if (!started) return;
      check(d == 0 ? "err_cnt0" : "err_cnt1", 64'(ecnt), 64'(m_cnt[d]));
      if (prev_rst[d]) check("out_valid_after_rst", 64'(ovld), 64'(0));
      prev_rst[d] = 1'b0;
      check("in_ready_rule", 64'(irdy), 64'(!ovld || out_ready));
      if (hold_v[d]) begin
         check("hold_valid", 64'(ovld), 64'(1));
         check("hold_sum", 64'(osum), 64'(hold_sum[d]));
         check("hold_mismatch", 64'(omis), 64'(hold_mis[d]));
      end
      hold_v[d]   = ovld && !out_ready;
      hold_sum[d] = osum;
      hold_mis[d] = omis;
      if (in_valid && irdy) q[d].push_back(model(a, b, cin, apx, (d == 0) ? 6 : 0));
      xfer = ovld && out_ready;
      e    = '0;
      if (xfer) begin
         if (q[d].size() == 0) begin
            check("unexpected_output", 64'(ovld), 64'(0));
         end else begin
            e = q[d].pop_front();
            pop_cnt[d]++;
            check(d == 0 ? "sum0" : "sum1", 64'(osum), 64'(e.sum));
            check(d == 0 ? "mismatch0" : "mismatch1", 64'(omis), 64'(e.mis));
         end
      end
      if (err_clr) m_cnt[d] = 0;
      else if (xfer && e.apx && e.mis && m_cnt[d] < emax) m_cnt[d]++;
   endtask

   // Sample both DUTs half a cycle away from the active edge
   always @(negedge clk) begin
      mon(0, if0.in_ready, if0.out_valid, if0.sum, if0.mismatch, 16'(err_cnt0), 15);
      mon(1, if1.in_ready, if1.out_valid, if1.sum, if1.mismatch, err_cnt1, 65535);
   end

   // Present one beat and wait for its acceptance edge; leaves in_valid high
   task automatic beat(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xx);
      int   n;
      logic acc;
      a = xa; b = xb; cin = xc; apx = xx; in_valid = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = if0.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("accept_timeout", 64'(acc), 64'(1));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q[0].size() != 0 || q[1].size() != 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", 64'(q[0].size() + q[1].size()), 64'(0));
   endtask

   // Single beat into an empty pipe: latency and absolute result on DUT0
   task automatic lat_check(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                            input logic xx, input logic [16:0] esum, input logic emis);
      int n;
      out_ready = 1'b1;
      beat(xa, xb, xc, xx);
      in_valid = 1'b0;
      n = 0;
      while (!if0.out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(n), 64'(2));
      check("abs_sum", 64'(if0.sum), 64'(esum));
      check("abs_mismatch", 64'(if0.mismatch), 64'(emis));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(if0.in_ready), 64'(1));
      check("rst_out_valid", 64'(if0.out_valid), 64'(0));
      check("rst_sum", 64'(if0.sum), 64'(0));
      check("rst_mismatch", 64'(if0.mismatch), 64'(0));
      check("rst_err_cnt", 64'(err_cnt0), 64'(0));
      rst = 1'b0;
      idle(2);

      // low-region carry dropped vs exact
      lat_check(16'h003F, 16'h0001, 1'b0, 1'b1, 17'h0003C, 1'b1);
      check("t1_err_cnt", 64'(err_cnt0), 64'(1));
      lat_check(16'h003F, 16'h0001, 1'b0, 1'b0, 17'h00040, 1'b1);
      check("t1_err_cnt_hold", 64'(err_cnt0), 64'(1));

      // upper-region propagation, carry_in only touching bit 0, full-width carry-out
      lat_check(16'hFF00, 16'h0100, 1'b0, 1'b1, 17'h10000, 1'b0);
      lat_check(16'h0001, 16'h0000, 1'b1, 1'b1, 17'h00000, 1'b1);
      lat_check(16'h0001, 16'h0000, 1'b1, 1'b0, 17'h00002, 1'b1);
      lat_check(16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h0FFFE, 1'b1);
      check("t2_err_cnt", 64'(err_cnt0), 64'(3));

      // back-to-back with an output stall
      p0 = pop_cnt[0];
      fork
         begin
            for (int i = 0; i < 8; i++)
               beat(16'(i * 16'h0111 + 5), 16'(i * 16'h00F3 + 16'h003F), i[0], i[1]);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check("t3_in_ready_stall", 64'(if0.in_ready), 64'(0));
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("t3_beat_count", 64'(pop_cnt[0] - p0), 64'(8));

      // saturation and clear priority on the 4-bit counter
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("t5_clr", 64'(err_cnt0), 64'(0));
      for (int i = 0; i < 20; i++) beat(16'h003F, 16'h0001, 1'b0, 1'b1);
      drain();
      check("t5_saturate", 64'(err_cnt0), 64'(15));
      out_ready = 1'b0;
      beat(16'h003F, 16'h0001, 1'b0, 1'b1);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t5_stalled_valid", 64'(if0.out_valid), 64'(1));
      err_clr   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("t5_clr_priority", 64'(err_cnt0), 64'(0));
      drain();

      // random stream with random back-pressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10000; i++)
               beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      // reset with two beats in flight
      p0 = pop_cnt[0];
      beat(16'h003F, 16'h0001, 1'b0, 1'b1);
      beat(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t6_out_valid", 64'(if0.out_valid), 64'(0));
      check("t6_err_cnt", 64'(err_cnt0), 64'(0));
      idle(4);
      check("t6_no_output", 64'(pop_cnt[0] - p0), 64'(0));
      lat_check(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
